// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and add/sub flag helper
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_NEGATIVE = 3;
    localparam int NUM_FLAGS     = 4;

    // Returns {carry, overflow} for ADD/SUB. ext is the extra top bit of the
    // zero-extended add/sub: carry-out for ADD, borrow for SUB.
    function automatic logic [1:0] addsub_flags(
        input logic is_sub,
        input logic a_msb,
        input logic b_msb,
        input logic r_msb,
        input logic ext
    );
        logic ovf;
        if (is_sub) begin
            ovf = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            ovf = (a_msb == b_msb) && (r_msb != a_msb);
        end
        return {ext, ovf};
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// rtl/alu_core_comb.sv - combinational ALU datapath producing result and flags
// Ports: a, b, op in; result and flags[NUM_FLAGS-1:0] (indexed by FLAG_*) out.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;
    logic [1:0]     add_cv;
    logic [1:0]     sub_cv;
    logic           carry;
    logic           overflow;

    always_comb begin
        sh       = b[SHW-1:0];
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        // One extra bit on each shift catches the last bit shifted out;
        // a zero shift leaves that bit 0, giving carry=0 for free.
        shl_ext  = {1'b0, a} << sh;
        shr_ext  = {a, 1'b0} >> sh;
        add_cv   = addsub_flags(1'b0, a[WIDTH-1], b[WIDTH-1], sum_ext[WIDTH-1], sum_ext[WIDTH]);
        sub_cv   = addsub_flags(1'b1, a[WIDTH-1], b[WIDTH-1], diff_ext[WIDTH-1], diff_ext[WIDTH]);

        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result            = sum_ext[WIDTH-1:0];
                {carry, overflow} = add_cv;
            end
            OP_SUB: begin
                result            = diff_ext[WIDTH-1:0];
                {carry, overflow} = sub_cv;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_ext[WIDTH-1:0];
                carry  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                result = shr_ext[WIDTH:1];
                carry  = shr_ext[0];
            end
            OP_SLTU: begin
                result = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
                carry  = diff_ext[WIDTH];
            end
            default: ;
        endcase

        flags                = '0;
        flags[FLAG_CARRY]    = carry;
        flags[FLAG_ZERO]     = (result == '0);
        flags[FLAG_OVERFLOW] = overflow;
        flags[FLAG_NEGATIVE] = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe_param.sv
// rtl/alu_pipe_param.sv - two-stage valid/ready ALU pipeline with op counter
// Ports: clk, rst; in_valid/in_ready with a, b, op; out_valid/out_ready with
// result, carry, zero, overflow, negative; op_count of output handshakes.
module alu_pipe_param
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               overflow,
    output logic               negative,
    output logic [COUNT_W-1:0] op_count
);

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    logic [2:0]           s1_op_q, s1_op_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [COUNT_W-1:0]   op_count_q, op_count_d;

    logic [WIDTH-1:0]     core_result;
    logic [NUM_FLAGS-1:0] core_flags;
    logic                 s2_adv;
    logic                 in_hs;
    logic                 out_hs;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (core_result),
        .flags  (core_flags)
    );

    always_comb begin
        // S2 may load when its slot is empty or being drained this cycle;
        // S1 may load when empty or moving into S2. No skid buffer.
        s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_adv;
        in_hs    = in_valid && in_ready;
        out_hs   = out_valid_q && out_ready;

        s1_valid_d = in_hs ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
        s1_a_d     = in_hs ? a  : s1_a_q;
        s1_b_d     = in_hs ? b  : s1_b_q;
        s1_op_d    = in_hs ? op : s1_op_q;

        out_valid_d = s2_adv ? 1'b1 : (out_hs ? 1'b0 : out_valid_q);
        result_d    = s2_adv ? core_result : result_q;
        flags_d     = s2_adv ? core_flags  : flags_q;

        op_count_d = op_count_q + COUNT_W'(out_hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = flags_q[FLAG_CARRY];
    assign zero      = flags_q[FLAG_ZERO];
    assign overflow  = flags_q[FLAG_OVERFLOW];
    assign negative  = flags_q[FLAG_NEGATIVE];
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb/tb_alu_pipe_param.sv - self-checking bench for alu_pipe_param
module tb_alu_pipe_param;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;
    logic          overflow;
    logic          negative;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_pipe_param #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow),
        .negative  (negative),
        .op_count  (op_count)
    );

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       v;
        logic       n;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    function automatic exp_t mk(input logic [7:0] r, input logic c, input logic z,
                                input logic v, input logic n);
        exp_t e;
        e.r = r; e.c = c; e.z = z; e.v = v; e.n = n;
        return e;
    endfunction

    // Reference model from the opcode rules using plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ua, ub, sa, sb, sh, full, sres;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        sh = int'(y[2:0]);
        e  = '0;
        case (o)
            3'd0: begin
                full = ua + ub; sres = sa + sb;
                e.r = full[7:0]; e.c = (full > 255); e.v = (sres > 127) || (sres < -128);
            end
            3'd1: begin
                full = ua - ub; sres = sa - sb;
                e.r = full[7:0]; e.c = (ua < ub); e.v = (sres > 127) || (sres < -128);
            end
            3'd2: e.r = x & y;
            3'd3: e.r = x | y;
            3'd4: e.r = x ^ y;
            3'd5: begin
                full = ua * (1 << sh);
                e.r = full[7:0];
                e.c = (sh == 0) ? 1'b0 : (((ua >> (8 - sh)) & 1) == 1);
            end
            3'd6: begin
                full = ua / (1 << sh);
                e.r = full[7:0];
                e.c = (sh == 0) ? 1'b0 : (((ua >> (sh - 1)) & 1) == 1);
            end
            default: begin
                e.r = (ua < ub) ? 8'd1 : 8'd0;
                e.c = (ua < ub);
            end
        endcase
        e.z = (e.r == 8'd0);
        e.n = e.r[7];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_result"},   32'(result),   32'(e.r));
        chk({tag, "_carry"},    32'(carry),    32'(e.c));
        chk({tag, "_zero"},     32'(zero),     32'(e.z));
        chk({tag, "_overflow"}, 32'(overflow), 32'(e.v));
        chk({tag, "_negative"}, 32'(negative), 32'(e.n));
    endtask

    // Single beat through an empty pipe with out_ready=1: checks 2-cycle
    // latency, the outputs, and the counter after the output handshake.
    task automatic directed(input string tag, input logic [2:0] o, input logic [7:0] x,
                            input logic [7:0] y, input exp_t e);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        chk_out(tag, e);
        exp_cnt++;
        tick();
        chk({tag, "_count"}, 32'(op_count), 32'(exp_cnt % 16));
    endtask

    exp_t q[$];
    exp_t e_pop;
    exp_t prev;
    logic stall_prev;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_out("rst", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("rst_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        directed("add_ovf",  OP_ADD,  8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
        directed("add_wrap", OP_ADD,  8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        directed("sub_ovf",  OP_SUB,  8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b0, 1'b1, 1'b0));
        directed("sub_brw",  OP_SUB,  8'h00, 8'h01, mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
        directed("shl_1",    OP_SHL,  8'h81, 8'h01, mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0));
        directed("shl_7",    OP_SHL,  8'h02, 8'h07, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        directed("shr_0",    OP_SHR,  8'h81, 8'h00, mk(8'h81, 1'b0, 1'b0, 1'b0, 1'b1));
        directed("shr_1",    OP_SHR,  8'h81, 8'h01, mk(8'h40, 1'b1, 1'b0, 1'b0, 1'b0));
        directed("sltu",     OP_SLTU, 8'h03, 8'h05, mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0));
        directed("and",      OP_AND,  8'hF0, 8'h3C, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0));
        directed("or",       OP_OR,   8'h80, 8'h01, mk(8'h81, 1'b0, 1'b0, 1'b0, 1'b1));
        directed("xor",      OP_XOR,  8'hFF, 8'hFF, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0));

        // Backpressure: two beats fill the pipe, the third waits.
        out_ready = 1'b0; op = OP_ADD;
        in_valid = 1'b1; a = 8'd1; b = 8'd1;
        #1;
        chk("bp_beat1_ready", 32'(in_ready), 32'd1);
        tick();
        a = 8'd2; b = 8'd2;
        #1;
        chk("bp_beat2_ready", 32'(in_ready), 32'd1);
        tick();
        a = 8'd3; b = 8'd3;
        #1;
        chk("bp_beat3_blocked", 32'(in_ready), 32'd0);
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_result", 32'(result), 32'h02);
        tick();
        chk("bp_still_blocked", 32'(in_ready), 32'd0);
        chk("bp_stable_result", 32'(result), 32'h02);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_out2_result", 32'(result), 32'h04);
        tick();
        chk("bp_out3_valid", 32'(out_valid), 32'd1);
        chk("bp_out3_result", 32'(result), 32'h06);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        exp_cnt += 3;
        chk("bp_count", 32'(op_count), 32'(exp_cnt % 16));

        // Counter wrap: 17 back-to-back handshakes on a 4-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1; op = OP_ADD; b = 8'd0;
        for (int i = 0; i < 17; i++) begin
            a = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        exp_cnt = 17;
        chk("wrap_count", 32'(op_count), 32'h1);

        // Reset with two beats in flight.
        out_ready = 1'b0; in_valid = 1'b1; op = OP_SUB; a = 8'h00; b = 8'h01;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk_out("mid_rst", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_cnt = 0;
        directed("post_rst", OP_ADD, 8'h10, 8'h20, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0));

        // Randomized traffic against the scoreboard.
        stall_prev = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = (cyc < 360) && ($urandom_range(0, 3) != 0);
            op        = 3'($urandom);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = (cyc >= 360) || ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk_out("rnd_hold", prev);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_beat", 32'd1, 32'(q.size()));
                end else begin
                    e_pop = q.pop_front();
                    chk_out("rnd", e_pop);
                    exp_cnt++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(op, a, b));
            stall_prev = out_valid && !out_ready;
            prev = mk(result, carry, zero, overflow, negative);
            tick();
        end
        in_valid = 1'b0;
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_count", 32'(op_count), 32'(exp_cnt % 16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
